instruction_controller: RTL and testbench

Instruction sequencer directly upstream of the data-cache `memory` block. On `start_in` it fetches 32-bit instructions from a program ROM with fixed read latency, executes control/scalar ops locally, and forwards data-path ops to `memory` as one-cycle `instr_valid_out` pulses. Control/scalar ops are XOR, ADDI, BGE, JUMP, NOP and END. Data-path ops are SMA, LOADI, SENDL, LOADB and WRITEB.

---
 rtl/gpu_isa_pkg.sv | 44 ++++
 rtl/scalar_regfile.sv | 35 +++
 rtl/instruction_controller.sv | 145 ++++++++++++++
 tb/tb_instruction_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions for the instruction sequencer and the data-cache memory block:
// opcode encoding, instruction field positions and the memory-forwarding classifier.
package gpu_isa_pkg;

   localparam int INSTRUCTION_WIDTH = 32;

   localparam int OPC_LSB = 28;
   localparam int OPC_W   = 4;
   localparam int RA_LSB  = 24;
   localparam int IMM_LSB = 8;
   localparam int IMM_W   = 16;
   localparam int RB_LSB  = 4;

   typedef enum logic [3:0] {
      OP_NOP    = 4'b0000,
      OP_END    = 4'b0001,
      OP_XOR    = 4'b0010,
      OP_ADDI   = 4'b0011,
      OP_BGE    = 4'b0100,
      OP_JUMP   = 4'b0101,
      OP_SMA    = 4'b0110,
      OP_LOADI  = 4'b0111,
      OP_LOADB  = 4'b1010,
      OP_WRITEB = 4'b1100,
      OP_SENDL  = 4'b1110
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_EXEC,
      ST_DONE
   } ctrl_state_e;

   // Opcodes that are not executed locally but handed to the memory block verbatim.
   function automatic logic is_mem_op(input logic [3:0] op);
      case (op)
         OP_SMA, OP_LOADI, OP_LOADB, OP_WRITEB, OP_SENDL: return 1'b1;
         default:                                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/scalar_regfile.sv
// Scalar register file: two combinational read ports, one synchronous write port,
// synchronous clear of every register on reset or on a clear request.
module scalar_regfile #(
   parameter  int REG_COUNT = 16,
   parameter  int REG_WIDTH = 16,
   localparam int ADDR_W    = $clog2(REG_COUNT)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 clr_in,
   input  logic                 wr_en_in,
   input  logic [ADDR_W-1:0]    wr_addr_in,
   input  logic [REG_WIDTH-1:0] wr_data_in,
   input  logic [ADDR_W-1:0]    rd_addr_a_in,
   input  logic [ADDR_W-1:0]    rd_addr_b_in,
   output logic [REG_WIDTH-1:0] rd_data_a_out,
   output logic [REG_WIDTH-1:0] rd_data_b_out
);

   logic [REG_WIDTH-1:0] r_regs [REG_COUNT];

   always_ff @(posedge clk_in) begin
      if (rst_in || clr_in) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (wr_en_in) begin
         r_regs[wr_addr_in] <= wr_data_in;
      end
   end

   assign rd_data_a_out = r_regs[rd_addr_a_in];
   assign rd_data_b_out = r_regs[rd_addr_b_in];

endmodule

// File: rtl/instruction_controller.sv
// Instruction sequencer: fetches from a fixed-latency program ROM, executes scalar and
// control ops locally and forwards data-path ops to the memory block as one-cycle pulses.
module instruction_controller #(
   parameter int INSTRUCTION_WIDTH = gpu_isa_pkg::INSTRUCTION_WIDTH,
   parameter int PROG_ADDR_WIDTH   = 10,
   parameter int REG_COUNT         = 16,
   parameter int REG_WIDTH         = 16,
   parameter int PROG_LATENCY      = 2
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start_in,
   output logic [PROG_ADDR_WIDTH-1:0]   prog_addr_out,
   input  logic [INSTRUCTION_WIDTH-1:0] prog_data_in,
   output logic [INSTRUCTION_WIDTH-1:0] instr_out,
   output logic                         instr_valid_out,
   output logic                         busy_out,
   output logic                         done_out
);
   import gpu_isa_pkg::*;

   localparam int RA_W      = $clog2(REG_COUNT);
   localparam int WAIT_W    = $clog2(PROG_LATENCY) + 1;
   localparam int WAIT_INIT = (PROG_LATENCY > 1) ? PROG_LATENCY - 2 : 0;

   ctrl_state_e                  r_state;
   logic [PROG_ADDR_WIDTH-1:0]   r_pc;
   logic                         r_cmp;
   logic [WAIT_W-1:0]            r_wait_cnt;
   logic [INSTRUCTION_WIDTH-1:0] r_instr;
   logic                         r_instr_valid;
   logic                         r_busy;
   logic                         r_done;

   logic [OPC_W-1:0]             w_opcode;
   logic [RA_W-1:0]              w_ra;
   logic [RA_W-1:0]              w_rb;
   logic [IMM_W-1:0]             w_imm;
   logic [REG_WIDTH-1:0]         w_ra_data;
   logic [REG_WIDTH-1:0]         w_rb_data;
   logic [REG_WIDTH-1:0]         w_wr_data;
   logic                         w_exec;
   logic                         w_start;
   logic                         w_wr_en;
   logic [PROG_ADDR_WIDTH-1:0]   w_pc_seq;
   logic [PROG_ADDR_WIDTH-1:0]   w_jump_target;

   assign w_opcode      = prog_data_in[OPC_LSB +: OPC_W];
   assign w_ra          = prog_data_in[RA_LSB +: RA_W];
   assign w_rb          = prog_data_in[RB_LSB +: RA_W];
   assign w_imm         = prog_data_in[IMM_LSB +: IMM_W];
   assign w_exec        = (r_state == ST_EXEC);
   assign w_start       = start_in && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_wr_en       = w_exec && ((w_opcode == OP_XOR) || (w_opcode == OP_ADDI));
   assign w_wr_data     = (w_opcode == OP_XOR) ? (w_ra_data ^ w_rb_data)
                                               : (w_rb_data + REG_WIDTH'(w_imm));
   assign w_pc_seq      = r_pc + PROG_ADDR_WIDTH'(1);
   assign w_jump_target = w_imm[PROG_ADDR_WIDTH-1:0];

   scalar_regfile #(
      .REG_COUNT (REG_COUNT),
      .REG_WIDTH (REG_WIDTH)
   ) u_regfile (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .clr_in        (w_start),
      .wr_en_in      (w_wr_en),
      .wr_addr_in    (w_ra),
      .wr_data_in    (w_wr_data),
      .rd_addr_a_in  (w_ra),
      .rd_addr_b_in  (w_rb),
      .rd_data_a_out (w_ra_data),
      .rd_data_b_out (w_rb_data)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state       <= ST_IDLE;
         r_pc          <= '0;
         r_cmp         <= 1'b0;
         r_wait_cnt    <= '0;
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_instr_valid <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start) begin
                  r_state <= ST_FETCH;
                  r_pc    <= '0;
                  r_cmp   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (PROG_LATENCY == 1) begin
                  r_state <= ST_EXEC;
               end else begin
                  r_state    <= ST_WAIT;
                  r_wait_cnt <= WAIT_W'(WAIT_INIT);
               end
            end
            ST_WAIT: begin
               if (r_wait_cnt == '0) begin
                  r_state <= ST_EXEC;
               end else begin
                  r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
               end
            end
            ST_EXEC: begin
               r_state <= ST_FETCH;
               r_pc    <= w_pc_seq;
               case (w_opcode)
                  OP_END: begin
                     r_state <= ST_DONE;
                     r_pc    <= r_pc;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
                  OP_BGE:  r_cmp <= (w_ra_data >= w_rb_data);
                  OP_JUMP: if (r_cmp) r_pc <= w_jump_target;
                  default: begin
                     // Undefined opcodes fall through here and act as NOP.
                     if (is_mem_op(w_opcode)) begin
                        r_instr       <= prog_data_in;
                        r_instr_valid <= 1'b1;
                     end
                  end
               endcase
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign prog_addr_out   = r_pc;
   assign instr_out       = r_instr;
   assign instr_valid_out = r_instr_valid;
   assign busy_out        = r_busy;
   assign done_out        = r_done;

endmodule

// File: tb/tb_instruction_controller.sv
// Bench for instruction_controller: an instruction-level interpreter builds the expected
// per-cycle output schedule, checked every cycle, plus hand-computed literal pins.
module tb_instruction_controller;
   import gpu_isa_pkg::*;

   localparam int LAT  = 2;
   localparam int IPC  = LAT + 1;
   localparam int MAXC = 400;
   localparam int TAIL = 3;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        start_in;
   logic [9:0]  prog_addr_out;
   logic [31:0] prog_data_in;
   logic [31:0] instr_out;
   logic        instr_valid_out;
   logic        busy_out;
   logic        done_out;

   logic [31:0] rom [0:1023];
   logic [31:0] rom_pipe [0:LAT-1];

   int n_vec = 0;
   int n_err = 0;

   logic [9:0]  exp_addr  [MAXC];
   logic        exp_busy  [MAXC];
   logic        exp_done  [MAXC];
   logic        exp_valid [MAXC];
   logic [31:0] exp_word  [MAXC];
   int          n_cyc;
   logic [31:0] m_held = '0;

   int          obs_pulses;
   int          obs_first_pulse;
   int          obs_done_at;
   logic [31:0] obs_last;

   instruction_controller #(
      .INSTRUCTION_WIDTH (32),
      .PROG_ADDR_WIDTH   (10),
      .REG_COUNT         (16),
      .REG_WIDTH         (16),
      .PROG_LATENCY      (LAT)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .start_in        (start_in),
      .prog_addr_out   (prog_addr_out),
      .prog_data_in    (prog_data_in),
      .instr_out       (instr_out),
      .instr_valid_out (instr_valid_out),
      .busy_out        (busy_out),
      .done_out        (done_out)
   );

   always #5 clk_in = ~clk_in;

   // ROM with LAT cycles of read latency
   always @(posedge clk_in) begin
      rom_pipe[0] <= rom[prog_addr_out];
      for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign prog_data_in = rom_pipe[LAT-1];

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] a,
                                      input logic [15:0] imm, input logic [3:0] b);
      return {op, a, imm, b, 4'h0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clear_rom();
      for (int j = 0; j < 1024; j++) rom[j] = '0;
   endtask

   // Interpret the program instruction by instruction; each one occupies IPC cycles
   // starting the cycle after start, and a forwarded word shows up on the first
   // cycle of the following instruction.
   task automatic build_model();
      logic [15:0] r [16];
      logic        c;
      logic [31:0] w;
      logic [15:0] imm;
      logic [3:0]  op;
      int          pc, i, k, a, b;
      bit          fin, pulse;
      c = 1'b0; pc = 0; i = 0; fin = 0; pulse = 0;
      for (int j = 0; j < 16; j++) r[j] = '0;
      while (!fin && ((i + 2) * IPC + TAIL < MAXC)) begin
         w   = rom[pc];
         op  = w[31:28];
         a   = int'(w[27:24]);
         imm = w[23:8];
         b   = int'(w[7:4]);
         for (int p = 0; p < IPC; p++) begin
            k = i * IPC + p;
            exp_addr[k]  = 10'(pc);
            exp_busy[k]  = 1'b1;
            exp_done[k]  = 1'b0;
            exp_valid[k] = (p == 0) && pulse;
            exp_word[k]  = m_held;
         end
         pulse = 0;
         case (op)
            4'b0001: fin = 1;
            4'b0010: begin r[a] = r[a] ^ r[b]; pc = (pc + 1) % 1024; end
            4'b0011: begin r[a] = r[b] + imm;  pc = (pc + 1) % 1024; end
            4'b0100: begin c = (r[a] >= r[b]); pc = (pc + 1) % 1024; end
            4'b0101: pc = c ? int'(imm[9:0]) : (pc + 1) % 1024;
            4'b0110, 4'b0111, 4'b1010, 4'b1100, 4'b1110: begin
               m_held = w; pulse = 1; pc = (pc + 1) % 1024;
            end
            default: pc = (pc + 1) % 1024;
         endcase
         if (!fin) i++;
      end
      for (int p = 0; p < TAIL; p++) begin
         k = (i + 1) * IPC + p;
         exp_addr[k]  = 10'(pc);
         exp_busy[k]  = 1'b0;
         exp_done[k]  = 1'b1;
         exp_valid[k] = 1'b0;
         exp_word[k]  = m_held;
      end
      n_cyc = (i + 1) * IPC + TAIL;
   endtask

   task automatic cmp_cycle(input int k);
      chk($sformatf("prog_addr@%0d", k), 32'(prog_addr_out), 32'(exp_addr[k]));
      chk($sformatf("busy@%0d", k), 32'(busy_out), 32'(exp_busy[k]));
      chk($sformatf("done@%0d", k), 32'(done_out), 32'(exp_done[k]));
      chk($sformatf("valid@%0d", k), 32'(instr_valid_out), 32'(exp_valid[k]));
      chk($sformatf("instr@%0d", k), instr_out, exp_word[k]);
      if (instr_valid_out) begin
         obs_pulses++;
         obs_last = instr_out;
         if (obs_first_pulse < 0) obs_first_pulse = k;
      end
      if (done_out && obs_done_at < 0) obs_done_at = k;
   endtask

   // Start the loaded program and check every cycle until a few cycles after END.
   task automatic run_prog(input string tag, input int busy_start_at);
      build_model();
      obs_pulses = 0; obs_first_pulse = -1; obs_done_at = -1; obs_last = '0;
      @(posedge clk_in); #1 start_in = 1'b1;
      @(posedge clk_in); #1 start_in = 1'b0;
      for (int k = 0; k < n_cyc; k++) begin
         @(negedge clk_in);
         cmp_cycle(k);
         @(posedge clk_in); #1;
         start_in = (k + 1 == busy_start_at);
      end
      start_in = 1'b0;
      $display("run %s: %0d cycles, %0d pulses, done at %0d", tag, n_cyc, obs_pulses, obs_done_at);
   endtask

   task automatic load_branch(input logic [15:0] r2val);
      clear_rom();
      rom[0] = mk(OP_ADDI, 4'd1, 16'd5, 4'd0);
      rom[1] = mk(OP_ADDI, 4'd2, r2val, 4'd0);
      rom[2] = mk(OP_BGE, 4'd1, 16'd0, 4'd2);
      rom[3] = mk(OP_JUMP, 4'd0, 16'd6, 4'd0);
      rom[4] = mk(OP_SMA, 4'd7, 16'hAAAA, 4'd0);
      rom[5] = mk(OP_END, 4'd0, 16'd0, 4'd0);
      rom[6] = mk(OP_LOADI, 4'd0, 16'h1234, 4'd0);
      rom[7] = mk(OP_END, 4'd0, 16'd0, 4'd0);
   endtask

   task automatic load_basic();
      clear_rom();
      rom[0] = mk(OP_SMA, 4'd2, 16'h0178, 4'd5);
      rom[1] = mk(OP_LOADI, 4'd0, 16'h8888, 4'd0);
      rom[2] = mk(OP_SENDL, 4'd1, 16'h0000, 4'd3) | 32'h9;
      rom[3] = mk(OP_END, 4'd0, 16'd0, 4'd0);
   endtask

   initial begin
      rst_in = 1'b1;
      start_in = 1'b0;
      clear_rom();
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b0;
      @(negedge clk_in);
      chk("rst_addr", 32'(prog_addr_out), 32'd0);
      chk("rst_instr", instr_out, 32'd0);
      chk("rst_valid", 32'(instr_valid_out), 32'd0);
      chk("rst_busy", 32'(busy_out), 32'd0);
      chk("rst_done", 32'(done_out), 32'd0);

      // Straight-line forwards
      load_basic();
      run_prog("basic", -1);
      chk("basic_pulses", 32'(obs_pulses), 32'd3);
      chk("basic_first_pulse", 32'(obs_first_pulse), 32'd3);
      chk("basic_done_at", 32'(obs_done_at), 32'd12);
      chk("basic_last", obs_last, 32'hE100_0039);

      // Taken and not-taken branch
      load_branch(16'd3);
      run_prog("branch_taken", -1);
      chk("taken_pulses", 32'(obs_pulses), 32'd1);
      chk("taken_last", obs_last, 32'h7012_3400);
      load_branch(16'd7);
      run_prog("branch_fall", -1);
      chk("fall_pulses", 32'(obs_pulses), 32'd1);
      chk("fall_last", obs_last, 32'h67AA_AA00);

      // ADDI wrap to 1, then XOR self to 0, each confirmed by an equality probe
      clear_rom();
      rom[0]  = mk(OP_ADDI, 4'd1, 16'hFFFF, 4'd0);
      rom[1]  = mk(OP_ADDI, 4'd1, 16'd2, 4'd1);
      rom[2]  = mk(OP_ADDI, 4'd3, 16'd1, 4'd0);
      rom[3]  = mk(OP_BGE, 4'd3, 16'd0, 4'd1);
      rom[4]  = mk(OP_JUMP, 4'd0, 16'd6, 4'd0);
      rom[5]  = mk(OP_END, 4'd0, 16'd0, 4'd0);
      rom[6]  = mk(OP_BGE, 4'd1, 16'd0, 4'd3);
      rom[7]  = mk(OP_JUMP, 4'd0, 16'd9, 4'd0);
      rom[8]  = mk(OP_END, 4'd0, 16'd0, 4'd0);
      rom[9]  = mk(OP_XOR, 4'd1, 16'd0, 4'd1);
      rom[10] = mk(OP_BGE, 4'd0, 16'd0, 4'd1);
      rom[11] = mk(OP_JUMP, 4'd0, 16'd13, 4'd0);
      rom[12] = mk(OP_END, 4'd0, 16'd0, 4'd0);
      rom[13] = mk(OP_SMA, 4'd0, 16'h0178, 4'd0);
      rom[14] = mk(OP_END, 4'd0, 16'd0, 4'd0);
      run_prog("wrap_xor", -1);
      chk("wrap_pulses", 32'(obs_pulses), 32'd1);
      chk("wrap_end_addr", 32'(prog_addr_out), 32'd14);

      // Counted loop: SMA for r1 = 0..3
      clear_rom();
      rom[0] = mk(OP_ADDI, 4'd2, 16'd3, 4'd0);
      rom[1] = mk(OP_SMA, 4'd1, 16'h0100, 4'd0);
      rom[2] = mk(OP_ADDI, 4'd1, 16'd1, 4'd1);
      rom[3] = mk(OP_BGE, 4'd2, 16'd0, 4'd1);
      rom[4] = mk(OP_JUMP, 4'd0, 16'd1, 4'd0);
      rom[5] = mk(OP_END, 4'd0, 16'd0, 4'd0);
      run_prog("loop", -1);
      chk("loop_pulses", 32'(obs_pulses), 32'd4);
      chk("loop_first_pulse", 32'(obs_first_pulse), 32'd6);
      chk("loop_done_at", 32'(obs_done_at), 32'd54);

      // Undefined opcode as NOP, start pulse while busy ignored
      clear_rom();
      rom[0] = mk(4'hF, 4'd1, 16'hFFFF, 4'd1);
      rom[1] = mk(OP_WRITEB, 4'd4, 16'h0C0C, 4'd2);
      rom[2] = mk(OP_END, 4'd0, 16'd0, 4'd0);
      run_prog("nop_busy_start", 5);
      chk("nop_pulses", 32'(obs_pulses), 32'd1);
      chk("nop_first_pulse", 32'(obs_first_pulse), 32'd6);
      chk("nop_done_at", 32'(obs_done_at), 32'd9);

      // pc wrap from 1023 back to 0
      clear_rom();
      rom[0]    = mk(OP_BGE, 4'd0, 16'd0, 4'd1);
      rom[1]    = mk(OP_JUMP, 4'd0, 16'd1023, 4'd0);
      rom[2]    = mk(OP_END, 4'd0, 16'd0, 4'd0);
      rom[1023] = mk(OP_ADDI, 4'd1, 16'd1, 4'd0);
      run_prog("pc_wrap", -1);
      chk("pcwrap_end_addr", 32'(prog_addr_out), 32'd2);
      chk("pcwrap_done_at", 32'(obs_done_at), 32'd18);

      // Reset during WAIT of a LOADI drops the forward
      clear_rom();
      rom[0] = mk(OP_LOADI, 4'd3, 16'h5A5A, 4'd1);
      @(posedge clk_in); #1 start_in = 1'b1;
      @(posedge clk_in); #1 start_in = 1'b0;
      @(posedge clk_in); #1 rst_in = 1'b1;
      @(posedge clk_in); #1 rst_in = 1'b0;
      m_held = '0;
      @(negedge clk_in);
      chk("rstmid_addr", 32'(prog_addr_out), 32'd0);
      chk("rstmid_instr", instr_out, 32'd0);
      chk("rstmid_valid", 32'(instr_valid_out), 32'd0);
      chk("rstmid_busy", 32'(busy_out), 32'd0);
      chk("rstmid_done", 32'(done_out), 32'd0);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk_in);
         chk($sformatf("rstmid_quiet_valid%0d", j), 32'(instr_valid_out), 32'd0);
         chk($sformatf("rstmid_quiet_busy%0d", j), 32'(busy_out), 32'd0);
      end
      @(posedge clk_in); #1;
      load_basic();
      run_prog("after_reset", -1);
      chk("after_reset_pulses", 32'(obs_pulses), 32'd3);
      chk("after_reset_first", 32'(obs_first_pulse), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
